// File: rtl/pcap_capture_mem_writer_pkg.sv
// Package for pcap_capture_mem_writer.
// Holds the FSM state encoding, the tuser field slices, the record header
// layout and the beat-count helper used for ring space checks.
package pcap_capture_mem_writer_pkg;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_DATA  = 3'd1;
    localparam logic [2:0] ST_TRUNC = 3'd2;
    localparam logic [2:0] ST_HDR   = 3'd3;
    localparam logic [2:0] ST_DROP  = 3'd4;

    // NetFPGA tuser slices: byte length and source port
    localparam int unsigned TUSER_LEN_LSB = 0;
    localparam int unsigned TUSER_LEN_W   = 16;
    localparam int unsigned TUSER_SRC_LSB = 16;
    localparam int unsigned TUSER_SRC_W   = 8;

    localparam int unsigned BEATS_W = 16;
    localparam int unsigned NEED_W  = 17;
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned TS_W    = 64;
    localparam int unsigned HDR_W   = 128;

    // Record header word, low 128 bits; remaining upper bits of the memory word are 0
    typedef struct packed {
        logic [TS_W-1:0]        ts;
        logic [22:0]            rsvd;
        logic                   trunc;
        logic [TUSER_SRC_W-1:0] src;
        logic [BEATS_W-1:0]     beats;
        logic [TUSER_LEN_W-1:0] len;
    } pcap_hdr_t;

    // Number of data beats for a byte length, rounded up (beat size is 2**beat_lg bytes)
    function automatic logic [NEED_W-1:0] beats_for_len(input logic [TUSER_LEN_W-1:0] len,
                                                        input int unsigned beat_lg);
        logic [31:0] bytes_up;
        bytes_up = 32'(len) + (32'd1 << beat_lg) - 32'd1;
        return NEED_W'(bytes_up >> beat_lg);
    endfunction

endpackage

// File: rtl/pcap_capture_mem_writer_if.sv
// Interface bundling the AXI4-Stream input and the packet-memory write port.
//   slave  : writer view (consumes stream, drives memory writes)
//   master : environment view (drives stream, accepts memory writes)
interface pcap_capture_mem_writer_if #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned TUSER_W = 128,
    parameter int unsigned ADDR_W  = 19
);
    logic [DATA_W-1:0]   s_axis_tdata;
    logic [DATA_W/8-1:0] s_axis_tstrb;
    logic [TUSER_W-1:0]  s_axis_tuser;
    logic                s_axis_tvalid;
    logic                s_axis_tready;
    logic                s_axis_tlast;

    logic                mem_wr_en;
    logic [ADDR_W-1:0]   mem_wr_addr;
    logic [DATA_W-1:0]   mem_wr_data;
    logic                mem_wr_ready;

    modport slave (
        input  s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        output s_axis_tready,
        output mem_wr_en, mem_wr_addr, mem_wr_data,
        input  mem_wr_ready
    );

    modport master (
        output s_axis_tdata, s_axis_tstrb, s_axis_tuser, s_axis_tvalid, s_axis_tlast,
        input  s_axis_tready,
        input  mem_wr_en, mem_wr_addr, mem_wr_data,
        output mem_wr_ready
    );
endinterface

// File: rtl/pcap_capture_mem_writer.sv
// pcap_capture_mem_writer: writes AXI4-Stream packets into a word-addressed
// packet memory ring as [header][data beats...]; packets that do not fit or
// arrive while capture is disabled are consumed and dropped whole.
// Ports:
//   axi_aclk, reset   clock, async active-high reset
//   bus (slave)       s_axis_* stream in, mem_wr_* write port out
//   capture_en        sampled at packet start
//   rd_ptr            consumer's next unread record start
//   wr_ptr            committed write pointer (next record start)
//   pkt_cnt/drop_cnt  committed / dropped packet counters (wrap)
// Optional: define PCAP_CAPTURE_TIMESTAMP_EN to place a 64-bit cycle count,
// sampled at the IDLE->DATA transition, in header[127:64].
module pcap_capture_mem_writer
    import pcap_capture_mem_writer_pkg::*;
#(
    parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
    parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
    parameter int unsigned MEM_ADDR_WIDTH       = 19
) (
    input  logic                      axi_aclk,
    input  logic                      reset,
    pcap_capture_mem_writer_if.slave  bus,
    input  logic                      capture_en,
    input  logic [MEM_ADDR_WIDTH-1:0] rd_ptr,
    output logic [MEM_ADDR_WIDTH-1:0] wr_ptr,
    output logic [CNT_W-1:0]          pkt_cnt,
    output logic [CNT_W-1:0]          drop_cnt
);

    localparam int unsigned DW      = C_S_AXIS_DATA_WIDTH;
    localparam int unsigned AW      = MEM_ADDR_WIDTH;
    localparam int unsigned BEAT_LG = $clog2(DW / 8);

    logic [2:0]             state, state_nxt;
    logic [TUSER_LEN_W-1:0] len_q;
    logic [TUSER_SRC_W-1:0] src_q;
    logic [AW-1:0]          base_q;
    logic [BEATS_W-1:0]     beat_q;
    logic [NEED_W-1:0]      need_q;
    logic                   trunc_q;

    logic                   start, beat_acc, set_trunc, commit, drop_done;
    logic [TUSER_LEN_W-1:0] len_in;
    logic [TUSER_SRC_W-1:0] src_in;
    logic [NEED_W-1:0]      need_in;
    logic [AW-1:0]          free;
    logic                   fits;
    logic [TS_W-1:0]        ts_val;
    pcap_hdr_t              hdr;
    logic                   unused_in;

    // Packet-start decision inputs
    assign len_in  = bus.s_axis_tuser[TUSER_LEN_LSB +: TUSER_LEN_W];
    assign src_in  = bus.s_axis_tuser[TUSER_SRC_LSB +: TUSER_SRC_W];
    assign need_in = beats_for_len(len_in, BEAT_LG) + NEED_W'(1);
    assign free    = rd_ptr - wr_ptr - AW'(1);
    assign fits    = capture_en && (len_in != '0) && (32'(need_in) <= 32'(free));

    assign unused_in = ^{bus.s_axis_tstrb,
                         bus.s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:TUSER_SRC_LSB+TUSER_SRC_W]};

    // Header word contents
    always_comb begin
        hdr       = '0;
        hdr.len   = len_q;
        hdr.beats = beat_q;
        hdr.src   = src_q;
        hdr.trunc = trunc_q;
        hdr.ts    = ts_val;
    end

`ifdef PCAP_CAPTURE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_cnt;
    logic [TS_W-1:0] ts_q;

    // Free-running cycle counter, captured when a packet is accepted for writing
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else begin
            ts_cnt <= ts_cnt + TS_W'(1);
            if (start && (state_nxt == ST_DATA)) ts_q <= ts_cnt;
        end
    end

    assign ts_val = ts_q;
`else
    assign ts_val = '0;
`endif

    // State register
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state, handshake and memory port
    always_comb begin
        state_nxt         = state;
        start             = 1'b0;
        beat_acc          = 1'b0;
        set_trunc         = 1'b0;
        commit            = 1'b0;
        drop_done         = 1'b0;
        bus.s_axis_tready = 1'b0;
        bus.mem_wr_en     = 1'b0;
        bus.mem_wr_addr   = '0;
        bus.mem_wr_data   = '0;
        case (state)
            ST_IDLE: begin
                if (bus.s_axis_tvalid) begin
                    start     = 1'b1;
                    state_nxt = fits ? ST_DATA : ST_DROP;
                end
            end
            ST_DATA: begin
                bus.mem_wr_addr   = base_q + AW'(1) + AW'(beat_q);
                bus.mem_wr_data   = bus.s_axis_tdata;
                bus.mem_wr_en     = bus.s_axis_tvalid;
                bus.s_axis_tready = bus.mem_wr_ready;
                if (bus.s_axis_tvalid && bus.mem_wr_ready) begin
                    beat_acc = 1'b1;
                    if (bus.s_axis_tlast) begin
                        state_nxt = ST_HDR;
                    end else if ((NEED_W'(beat_q) + NEED_W'(1)) == (need_q - NEED_W'(1))) begin
                        // Reserved space is full but the packet continues
                        set_trunc = 1'b1;
                        state_nxt = ST_TRUNC;
                    end
                end
            end
            ST_TRUNC: begin
                bus.s_axis_tready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) state_nxt = ST_HDR;
            end
            ST_HDR: begin
                bus.mem_wr_addr = base_q;
                bus.mem_wr_data = DW'(hdr);
                bus.mem_wr_en   = 1'b1;
                if (bus.mem_wr_ready) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            ST_DROP: begin
                bus.s_axis_tready = 1'b1;
                if (bus.s_axis_tvalid && bus.s_axis_tlast) begin
                    drop_done = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Record context, write pointer and counters; wr_ptr moves only on header commit
    always_ff @(posedge axi_aclk or posedge reset) begin
        if (reset) begin
            len_q    <= '0;
            src_q    <= '0;
            base_q   <= '0;
            beat_q   <= '0;
            need_q   <= '0;
            trunc_q  <= 1'b0;
            wr_ptr   <= '0;
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (start) begin
                len_q   <= len_in;
                src_q   <= src_in;
                base_q  <= wr_ptr;
                beat_q  <= '0;
                need_q  <= need_in;
                trunc_q <= 1'b0;
            end
            if (beat_acc)  beat_q  <= beat_q + BEATS_W'(1);
            if (set_trunc) trunc_q <= 1'b1;
            if (commit) begin
                wr_ptr  <= base_q + AW'(beat_q) + AW'(1);
                pkt_cnt <= pkt_cnt + CNT_W'(1);
            end
            if (drop_done) drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pcap_capture_mem_writer.sv
// Directed self-checking bench for pcap_capture_mem_writer (16-word ring).
module tb_pcap_capture_mem_writer;

    localparam int unsigned DW = 256;
    localparam int unsigned TW = 128;
    localparam int unsigned AW = 4;

    logic          clk;
    logic          rst;
    logic          capture_en;
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_cnt;

    int n_chk;
    int n_err;

    pcap_capture_mem_writer_if #(.DATA_W(DW), .TUSER_W(TW), .ADDR_W(AW)) bus ();

    pcap_capture_mem_writer #(
        .C_S_AXIS_DATA_WIDTH (DW),
        .C_S_AXIS_TUSER_WIDTH(TW),
        .MEM_ADDR_WIDTH      (AW)
    ) dut (
        .axi_aclk  (clk),
        .reset     (rst),
        .bus       (bus),
        .capture_en(capture_en),
        .rd_ptr    (rd_ptr),
        .wr_ptr    (wr_ptr),
        .pkt_cnt   (pkt_cnt),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write log and handshake monitor, sampled on the falling edge
    logic [AW-1:0] wa[$];
    logic [DW-1:0] wd[$];
    logic          pend;
    logic [AW-1:0] pend_a;
    logic [DW-1:0] pend_d;
    int            hold_err;
    logic          stall_phase;
    int            stall_tready;
    int            stall_en;

    initial begin
        pend = 1'b0; hold_err = 0; stall_phase = 1'b0; stall_tready = 0; stall_en = 0;
    end

    always @(negedge clk) begin
        if (bus.mem_wr_en) begin
            if (pend && (bus.mem_wr_addr != pend_a || bus.mem_wr_data != pend_d)) hold_err++;
            if (bus.mem_wr_ready) begin
                pend = 1'b0;
                wa.push_back(bus.mem_wr_addr);
                wd.push_back(bus.mem_wr_data);
            end else begin
                pend = 1'b1; pend_a = bus.mem_wr_addr; pend_d = bus.mem_wr_data;
            end
        end else begin
            pend = 1'b0;
        end
        if (stall_phase) begin
            if (bus.s_axis_tready) stall_tready++;
            if (bus.mem_wr_en)     stall_en++;
        end
    end

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] bd(input logic [7:0] tag, input int i);
        return {tag, 8'(i), 224'd0, tag, 8'(i)};
    endfunction

    function automatic logic [DW-1:0] hdr(input logic [15:0] len, input logic [15:0] beats,
                                         input logic [7:0] src, input logic trunc);
        return DW'({64'd0, 23'd0, trunc, src, beats, len});
    endfunction

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic chk_wr(input string tag, input int idx, input logic [AW-1:0] ea,
                          input logic [DW-1:0] ed);
        if (idx < wa.size()) begin
            chk({tag, "_addr"}, DW'(wa[idx]), DW'(ea));
            chk({tag, "_data"}, wd[idx], ed);
        end else begin
            chk({tag, "_count"}, DW'(wa.size()), DW'(idx + 1));
        end
    endtask

    int beat_cycles;

    // Present one beat and hold it until accepted (bounded)
    task automatic drive_beat(input logic [DW-1:0] d, input logic last);
        logic acc;
        int   g;
        bus.s_axis_tdata  = d;
        bus.s_axis_tlast  = last;
        bus.s_axis_tvalid = 1'b1;
        acc = 1'b0;
        g   = 0;
        while (!acc && g < 100) begin
            @(negedge clk);
            acc = bus.s_axis_tready;
            g++;
            beat_cycles++;
            @(posedge clk);
            #1;
        end
        chk("beat_accept", DW'(acc), DW'(1));
    endtask

    task automatic send_pkt(input logic [15:0] len, input int nbeats, input logic [7:0] src,
                            input logic [7:0] tag);
        beat_cycles = 0;
        bus.s_axis_tuser = TW'({src, len});
        for (int i = 0; i < nbeats; i++) drive_beat(bd(tag, i), i == nbeats - 1);
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // Wait (bounded) until committed+dropped reaches the expected total
    task automatic wait_done(input string tag, input int exp_total);
        int g;
        g = 0;
        while (int'(pkt_cnt + drop_cnt) != exp_total && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk(tag, DW'(pkt_cnt + drop_cnt), DW'(exp_total));
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst = 1'b1;
        capture_en = 1'b1;
        rd_ptr = '0;
        bus.s_axis_tdata  = '0;
        bus.s_axis_tstrb  = '1;
        bus.s_axis_tuser  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.mem_wr_ready  = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_tready", DW'(bus.s_axis_tready), '0);
        chk("rst_wr_en", DW'(bus.mem_wr_en), '0);
        chk("rst_addr", DW'(bus.mem_wr_addr), '0);
        chk("rst_data", bus.mem_wr_data, '0);
        chk("rst_wr_ptr", DW'(wr_ptr), '0);
        chk("rst_cnts", DW'({pkt_cnt, drop_cnt}), '0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #1;

        // 64B packet from empty ring
        clear_log();
        send_pkt(16'd64, 2, 8'd3, 8'h11);
        wait_done("t1_done", 1);
        chk("t1_nwr", DW'(wa.size()), DW'(3));
        chk_wr("t1_w0", 0, 4'd1, bd(8'h11, 0));
        chk_wr("t1_w1", 1, 4'd2, bd(8'h11, 1));
        chk_wr("t1_hdr", 2, 4'd0, hdr(16'd64, 16'd2, 8'd3, 1'b0));
        chk("t1_wr_ptr", DW'(wr_ptr), DW'(3));
        chk("t1_pkt_cnt", DW'(pkt_cnt), DW'(1));

        // 320B packet fills to 14, then 96B packet wraps across the top
        rd_ptr = 4'd3;
        send_pkt(16'd320, 10, 8'd1, 8'h20);
        wait_done("t2a_done", 2);
        chk("t2a_wr_ptr", DW'(wr_ptr), DW'(14));
        rd_ptr = 4'd14;
        clear_log();
        send_pkt(16'd96, 3, 8'd5, 8'h22);
        wait_done("t2_done", 3);
        chk("t2_nwr", DW'(wa.size()), DW'(4));
        chk_wr("t2_w0", 0, 4'd15, bd(8'h22, 0));
        chk_wr("t2_w1", 1, 4'd0, bd(8'h22, 1));
        chk_wr("t2_w2", 2, 4'd1, bd(8'h22, 2));
        chk_wr("t2_hdr", 3, 4'd14, hdr(16'd96, 16'd3, 8'd5, 1'b0));
        chk("t2_wr_ptr", DW'(wr_ptr), DW'(2));

        // Insufficient space: free=2, 128B needs 5 -> dropped, tready held high
        rd_ptr = 4'd5;
        clear_log();
        send_pkt(16'd128, 4, 8'd2, 8'h30);
        wait_done("t3_done", 4);
        chk("t3_cycles", DW'(beat_cycles), DW'(5));
        chk("t3_nwr", DW'(wa.size()), '0);
        chk("t3_drop_cnt", DW'(drop_cnt), DW'(1));
        chk("t3_wr_ptr", DW'(wr_ptr), DW'(2));

        // Exact fit: 32B needs 2 = free
        clear_log();
        send_pkt(16'd32, 1, 8'd4, 8'h31);
        wait_done("t3b_done", 5);
        chk_wr("t3b_w0", 0, 4'd3, bd(8'h31, 0));
        chk_wr("t3b_hdr", 1, 4'd2, hdr(16'd32, 16'd1, 8'd4, 1'b0));
        chk("t3b_wr_ptr", DW'(wr_ptr), DW'(4));

        // Capture disabled, and zero-length packet: both dropped
        rd_ptr = 4'd4;
        capture_en = 1'b0;
        clear_log();
        send_pkt(16'd64, 2, 8'd1, 8'h40);
        wait_done("t3c_done", 6);
        capture_en = 1'b1;
        send_pkt(16'd0, 1, 8'd1, 8'h41);
        wait_done("t3d_done", 7);
        chk("t3cd_nwr", DW'(wa.size()), '0);
        chk("t3cd_drop_cnt", DW'(drop_cnt), DW'(3));
        chk("t3cd_wr_ptr", DW'(wr_ptr), DW'(4));

        // mem_wr_ready low for 3 cycles in DATA
        clear_log();
        hold_err = 0; stall_tready = 0; stall_en = 0;
        fork
            send_pkt(16'd96, 3, 8'd6, 8'h50);
            begin
                int g;
                g = 0;
                while (wa.size() == 0 && g < 50) begin
                    @(negedge clk);
                    g++;
                end
                @(posedge clk); #1;
                bus.mem_wr_ready = 1'b0;
                stall_phase = 1'b1;
                repeat (3) @(posedge clk);
                #1;
                bus.mem_wr_ready = 1'b1;
                stall_phase = 1'b0;
            end
        join
        wait_done("t4_done", 8);
        chk("t4_nwr", DW'(wa.size()), DW'(4));
        chk_wr("t4_w0", 0, 4'd5, bd(8'h50, 0));
        chk_wr("t4_w1", 1, 4'd6, bd(8'h50, 1));
        chk_wr("t4_w2", 2, 4'd7, bd(8'h50, 2));
        chk_wr("t4_hdr", 3, 4'd4, hdr(16'd96, 16'd3, 8'd6, 1'b0));
        chk("t4_hold", DW'(hold_err), '0);
        chk("t4_stall_tready", DW'(stall_tready), '0);
        chk("t4_stall_en", DW'(stall_en), DW'(3));
        chk("t4_wr_ptr", DW'(wr_ptr), DW'(8));

        // Truncation: tuser says 64B, 4 beats arrive
        rd_ptr = 4'd8;
        clear_log();
        send_pkt(16'd64, 4, 8'd7, 8'h60);
        wait_done("t5_done", 9);
        chk("t5_nwr", DW'(wa.size()), DW'(3));
        chk_wr("t5_w0", 0, 4'd9, bd(8'h60, 0));
        chk_wr("t5_w1", 1, 4'd10, bd(8'h60, 1));
        chk_wr("t5_hdr", 2, 4'd8, hdr(16'd64, 16'd2, 8'd7, 1'b1));
        chk("t5_wr_ptr", DW'(wr_ptr), DW'(11));
        chk("t5_pkt_cnt", DW'(pkt_cnt), DW'(6));

        // Reset in DATA after one beat
        rd_ptr = 4'd11;
        bus.s_axis_tuser = TW'({8'd8, 16'd96});
        beat_cycles = 0;
        drive_beat(bd(8'h70, 0), 1'b0);
        bus.s_axis_tdata = bd(8'h70, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_tready", DW'(bus.s_axis_tready), '0);
        chk("t6_wr_en", DW'(bus.mem_wr_en), '0);
        chk("t6_addr", DW'(bus.mem_wr_addr), '0);
        chk("t6_data", bus.mem_wr_data, '0);
        chk("t6_wr_ptr", DW'(wr_ptr), '0);
        chk("t6_cnts", DW'({pkt_cnt, drop_cnt}), '0);
        bus.s_axis_tvalid = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        rd_ptr = 4'd0;
        @(posedge clk); #1;
        clear_log();
        send_pkt(16'd32, 1, 8'd9, 8'h71);
        wait_done("t6_done", 1);
        chk("t6_nwr", DW'(wa.size()), DW'(2));
        chk_wr("t6_w0", 0, 4'd1, bd(8'h71, 0));
        chk_wr("t6_hdr", 1, 4'd0, hdr(16'd32, 16'd1, 8'd9, 1'b0));
        chk("t6_wr_ptr_after", DW'(wr_ptr), DW'(2));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
